// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: command-driven configure/arm/count controller for the sequence detector
module seq_detect_ctrl #(
  parameter int PAT_W   = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  output logic [PAT_W-1:0] det_pat,
  output logic [3:0]       det_len,
  output logic             det_clr,
  output logic             det_en,
  input  logic             det_hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             done,
  output logic             timed_out,
  output logic             busy
);
  localparam int TW = $clog2(TMO_CYC) + 1;
  typedef enum logic [1:0] {IDLE, FLUSH, ARMED, DONE} state_t;
  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [3:0]       len_q, len_d, len_clamp;
  logic [CNT_W-1:0] target_q, target_d, cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_next;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             to_q, to_d, acc;
  assign cmd_ready = (state_q == IDLE) || (state_q == ARMED);
  assign acc       = cmd_valid && cmd_ready;
  assign len_clamp = (cmd_data[3:0] == 4'd0) ? 4'd1 :
                     (cmd_data[3:0] > 4'(PAT_W)) ? 4'(PAT_W) : cmd_data[3:0];
  assign cnt_next  = {1'b0, cnt_q} + 1'b1;
  assign det_pat   = pat_q;
  assign det_len   = len_q;
  assign det_clr   = state_q == FLUSH;
  assign det_en    = state_q == ARMED;
  assign done      = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign hit_count = cnt_q;
  assign timed_out = to_q;
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    to_d     = to_q;
    case (state_q)
      IDLE: if (acc) begin
        if (cmd_op == 2'd0) pat_d = cmd_data[PAT_W-1:0];
        if (cmd_op == 2'd1) len_d = len_clamp;
        if (cmd_op == 2'd2) begin
          target_d = CNT_W'(cmd_data);
          cnt_d    = '0;
          to_d     = 1'b0;
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        tmo_d   = '0;
        state_d = ARMED;
      end
      ARMED:
        // abort outranks a coincident hit; a hit outranks a coincident timeout
        if (acc && cmd_op == 2'd3) state_d = DONE;
        else if (det_hit) begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_next[CNT_W-1:0];
          tmo_d = '0;
          if (target_q != '0 && cnt_next == {1'b0, target_q}) state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TW'(TMO_CYC - 1)) begin
            state_d = DONE;
            to_d    = 1'b1;
          end
        end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      len_q    <= 4'(PAT_W);
      target_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      to_q     <= to_d;
    end
  end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed scenario tests for seq_detect_ctrl
module tb_seq_detect_ctrl;
  logic       clk = 0, rst = 1, cmd_valid = 0, det_hit = 0;
  logic [1:0] cmd_op = 0;
  logic [7:0] cmd_data = 0;
  logic       cmd_ready, det_clr, det_en, done, timed_out, busy;
  logic [7:0] det_pat, hit_count;
  logic [3:0] det_len;
  int         n_cmp = 0, n_err = 0;

  seq_detect_ctrl #(.PAT_W(8), .CNT_W(8), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .det_pat(det_pat), .det_len(det_len),
    .det_clr(det_clr), .det_en(det_en), .det_hit(det_hit), .hit_count(hit_count),
    .done(done), .timed_out(timed_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] d);
    cmd_valid = 1; cmd_op = op; cmd_data = d;
    step();
    cmd_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1; step(2); rst = 0;
    n_cmp++;
    if ({det_pat, det_len, det_clr, det_en, hit_count, done, timed_out, busy, cmd_ready} !== {8'h00, 4'd8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state got pat=%h len=%0d clr=%b en=%b cnt=%0d done=%b to=%b busy=%b rdy=%b", det_pat, det_len, det_clr, det_en, hit_count, done, timed_out, busy, cmd_ready);
    end
  endtask

  task automatic test_config;
    cmd(2'd0, 8'hB5); cmd(2'd1, 8'd6);
    n_cmp++;
    if ({det_pat, det_len} !== {8'hB5, 4'd6}) begin n_err++; $display("FAIL set_pat_len got %h/%0d exp b5/6", det_pat, det_len); end
    cmd(2'd1, 8'd0);
    n_cmp++;
    if (det_len !== 4'd1) begin n_err++; $display("FAIL len_clamp_low got %0d exp 1", det_len); end
    cmd(2'd1, 8'd12);
    n_cmp++;
    if (det_len !== 4'd8) begin n_err++; $display("FAIL len_clamp_high got %0d exp 8", det_len); end
  endtask

  task automatic test_arm_target;
    cmd(2'd2, 8'd3);
    n_cmp++;
    if ({det_clr, det_en, busy, cmd_ready} !== 4'b1010) begin n_err++; $display("FAIL flush_cycle got clr/en/busy/rdy=%b%b%b%b exp 1010", det_clr, det_en, busy, cmd_ready); end
    step();
    n_cmp++;
    if ({det_clr, det_en, cmd_ready} !== 3'b011) begin n_err++; $display("FAIL armed_cycle got clr/en/rdy=%b%b%b exp 011", det_clr, det_en, cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      det_hit = 1; step(); det_hit = 0;
      if (i < 2) step();
    end
    n_cmp++;
    if ({done, hit_count, timed_out, det_en} !== {1'b1, 8'd3, 1'b0, 1'b0}) begin n_err++; $display("FAIL target_done got done=%b cnt=%0d to=%b en=%b exp 1/3/0/0", done, hit_count, timed_out, det_en); end
    step();
    n_cmp++;
    if ({done, busy, hit_count} !== {1'b0, 1'b0, 8'd3}) begin n_err++; $display("FAIL target_idle got done=%b busy=%b cnt=%0d exp 0/0/3", done, busy, hit_count); end
  endtask

  task automatic test_timeout;
    cmd(2'd2, 8'd5);
    step();
    step(4);
    det_hit = 1; step(); det_hit = 0;
    step(15);
    n_cmp++;
    if ({done, busy} !== 2'b01) begin n_err++; $display("FAIL tmo_early got done=%b busy=%b exp 0/1", done, busy); end
    step();
    n_cmp++;
    if ({done, timed_out, hit_count} !== {1'b1, 1'b1, 8'd1}) begin n_err++; $display("FAIL tmo_done got done=%b to=%b cnt=%0d exp 1/1/1", done, timed_out, hit_count); end
    step();
    n_cmp++;
    if ({busy, timed_out} !== 2'b01) begin n_err++; $display("FAIL tmo_sticky got busy=%b to=%b exp 0/1", busy, timed_out); end
  endtask

  task automatic test_saturate;
    cmd(2'd2, 8'd0);
    step();
    det_hit = 1; step(300); det_hit = 0;
    n_cmp++;
    if ({hit_count, busy, timed_out} !== {8'd255, 1'b1, 1'b0}) begin n_err++; $display("FAIL saturate got cnt=%0d busy=%b to=%b exp 255/1/0", hit_count, busy, timed_out); end
    cmd(2'd3, 8'd0);
    n_cmp++;
    if ({done, timed_out, hit_count} !== {1'b1, 1'b0, 8'd255}) begin n_err++; $display("FAIL abort_done got done=%b to=%b cnt=%0d exp 1/0/255", done, timed_out, hit_count); end
    step();
  endtask

  task automatic test_drop;
    cmd(2'd2, 8'd0);
    step();
    cmd(2'd0, 8'h0F); cmd(2'd1, 8'd3);
    n_cmp++;
    if ({det_pat, det_len, busy} !== {8'hB5, 4'd8, 1'b1}) begin n_err++; $display("FAIL cfg_dropped got pat=%h len=%0d busy=%b exp b5/8/1", det_pat, det_len, busy); end
    cmd(2'd2, 8'd1);
    det_hit = 1; step(); det_hit = 0;
    n_cmp++;
    if ({hit_count, busy, done} !== {8'd1, 1'b1, 1'b0}) begin n_err++; $display("FAIL rearm_dropped got cnt=%0d busy=%b done=%b exp 1/1/0", hit_count, busy, done); end
    det_hit = 1; cmd(2'd3, 8'd0); det_hit = 0;
    n_cmp++;
    if ({done, hit_count, timed_out} !== {1'b1, 8'd1, 1'b0}) begin n_err++; $display("FAIL abort_hit got done=%b cnt=%0d to=%b exp 1/1/0", done, hit_count, timed_out); end
    step();
    det_hit = 1; step(); det_hit = 0; step();
    n_cmp++;
    if ({hit_count, busy} !== {8'd1, 1'b0}) begin n_err++; $display("FAIL idle_hit got cnt=%0d busy=%b exp 1/0", hit_count, busy); end
  endtask

  task automatic test_rst_armed;
    cmd(2'd2, 8'd0);
    step();
    det_hit = 1; step(2); det_hit = 0;
    n_cmp++;
    if (hit_count !== 8'd2) begin n_err++; $display("FAIL pre_rst_count got %0d exp 2", hit_count); end
    rst = 1; step(); rst = 0;
    n_cmp++;
    if ({busy, det_en, hit_count, done, cmd_ready} !== {1'b0, 1'b0, 8'd0, 1'b0, 1'b1}) begin n_err++; $display("FAIL rst_armed got busy=%b en=%b cnt=%0d done=%b rdy=%b exp 0/0/0/0/1", busy, det_en, hit_count, done, cmd_ready); end
    step();
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL rst_no_done got %b exp 0", done); end
  endtask

  task automatic test_boundary;
    cmd(2'd2, 8'd0);
    step();
    step(15);
    det_hit = 1; step(); det_hit = 0;
    n_cmp++;
    if ({busy, done, timed_out, hit_count} !== {1'b1, 1'b0, 1'b0, 8'd1}) begin n_err++; $display("FAIL hit_at_tmo got busy=%b done=%b to=%b cnt=%0d exp 1/0/0/1", busy, done, timed_out, hit_count); end
    step(15);
    n_cmp++;
    if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL tmo_restart got busy=%b done=%b exp 1/0", busy, done); end
    step();
    n_cmp++;
    if ({done, timed_out, hit_count} !== {1'b1, 1'b1, 8'd1}) begin n_err++; $display("FAIL tmo_after_hit got done=%b to=%b cnt=%0d exp 1/1/1", done, timed_out, hit_count); end
    step();
  endtask

  initial begin
    test_reset();
    test_config();
    test_arm_target();
    test_timeout();
    test_saturate();
    test_drop();
    test_rst_armed();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
